// File: rtl/axi_wr_mem.sv
// AXI write-only slave: accepts one AW/W pair at a time, commits the beat into a
// word-addressed memory, returns B, and exposes a registered side read port.
module axi_wr_mem #(
  parameter int          NWORDS    = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  localparam int         IW        = $clog2(NWORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          axi_awvalid,
  output logic          axi_awready,
  input  logic [63:0]   axi_awaddr,
  input  logic          axi_wvalid,
  output logic          axi_wready,
  input  logic [255:0]  axi_wdata,
  output logic          axi_bvalid,
  input  logic          axi_bready,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_addr,
  output logic [255:0]  rd_data,
  output logic [31:0]   wr_count,
  output logic [15:0]   err_count
);

  localparam int DATA_W = 256;

  logic              r_aw_held;
  logic              r_w_held;
  logic              r_bvalid;
  logic [63:0]       r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mem [NWORDS];
  logic [DATA_W-1:0] r_rd_data;
  logic [31:0]       r_wr_count;
  logic [15:0]       r_err_count;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [64:0]       w_base;
  logic [64:0]       w_end;
  logic [64:0]       w_addr;
  logic [64:0]       w_diff;
  logic              w_in_range;
  logic [IW-1:0]     w_idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Readies depend only on held state so a stalled master never sees a
  // ready that was conditioned on its own valid.
  assign axi_awready = !r_aw_held && !r_bvalid;
  assign axi_wready  = !r_w_held && !r_bvalid;
  assign w_aw_hs     = axi_awvalid && axi_awready;
  assign w_w_hs      = axi_wvalid && axi_wready;
  assign w_commit    = r_aw_held && r_w_held;

  // 65-bit window so BASE_ADDR + 32*NWORDS cannot wrap at the top of memory.
  assign w_base     = {1'b0, BASE_ADDR};
  assign w_end      = w_base + (65'(NWORDS) << 5);
  assign w_addr     = {1'b0, r_addr};
  assign w_diff     = w_addr - w_base;
  assign w_idx      = IW'(w_diff >> 5);
  assign w_in_range = (w_addr >= w_base) && (w_addr < w_end) && (r_addr[4:0] == 5'd0);

  assign axi_bvalid = r_bvalid;
  assign rd_data    = r_rd_data;
  assign wr_count   = r_wr_count;
  assign err_count  = r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_wr_count  <= 32'd0;
      r_err_count <= 16'd0;
      r_rd_data   <= '0;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_in_range) r_wr_count  <= r_wr_count + 32'd1;
        else            r_err_count <= sat_inc16(r_err_count);
      end else begin
        if (w_aw_hs)                r_aw_held <= 1'b1;
        if (w_w_hs)                 r_w_held  <= 1'b1;
        if (r_bvalid && axi_bready) r_bvalid  <= 1'b0;
      end
      if (rd_en) r_rd_data <= r_mem[rd_addr];
    end
  end

  // Payload registers and memory carry no reset; the held flags qualify them.
  always_ff @(posedge clk) begin
    if (w_aw_hs)                 r_addr       <= axi_awaddr;
    if (w_w_hs)                  r_data       <= axi_wdata;
    if (w_commit && w_in_range)  r_mem[w_idx] <= r_data;
  end

endmodule

// File: tb/tb_axi_wr_mem.sv
// Scoreboard bench for axi_wr_mem: B handshakes are checked against queued
// counter snapshots, side reads against a queued reference memory.
module tb_axi_wr_mem;
  localparam int          NW   = 16;
  localparam int          IW   = 4;
  localparam logic [63:0] BASE = 64'h1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          axi_awvalid = 1'b0;
  logic          axi_awready;
  logic [63:0]   axi_awaddr = '0;
  logic          axi_wvalid = 1'b0;
  logic          axi_wready;
  logic [255:0]  axi_wdata = '0;
  logic          axi_bvalid;
  logic          axi_bready = 1'b1;
  logic          rd_en = 1'b0;
  logic [IW-1:0] rd_addr = '0;
  logic [255:0]  rd_data;
  logic [31:0]   wr_count;
  logic [15:0]   err_count;

  axi_wr_mem #(.NWORDS(NW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] m_mem [NW];
  logic [31:0]  m_wr  = '0;
  logic [15:0]  m_err = '0;
  logic [31:0]  q_wr  [$];
  logic [15:0]  q_err [$];
  logic [255:0] q_rd  [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(32 * NW)) && (a[4:0] == 5'd0);
  endfunction

  task automatic expect_write(input logic [63:0] addr, input logic [255:0] data);
    int idx;
    if (in_rng(addr)) begin
      idx = int'((addr - BASE) >> 5);
      m_mem[idx] = data;
      m_wr = m_wr + 32'd1;
    end else if (m_err != 16'hFFFF) begin
      m_err = m_err + 16'd1;
    end
    q_wr.push_back(m_wr);
    q_err.push_back(m_err);
  endtask

  // Every B handshake is compared against the counter snapshot of its write.
  always @(negedge clk) begin
    if (!rst && axi_bvalid && axi_bready) begin
      if (q_wr.size() == 0) begin
        chk("b_unexpected", 256'(1), 256'(0));
      end else begin
        chk("b_wr_count", 256'(wr_count), 256'(q_wr.pop_front()));
        chk("b_err_count", 256'(err_count), 256'(q_err.pop_front()));
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(axi_awready && axi_wready && !axi_bvalid) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk({tag, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic wr(input logic [63:0] addr, input logic [255:0] data);
    wait_idle("wr_pre");
    expect_write(addr, data);
    axi_awaddr  = addr;
    axi_wdata   = data;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    wait_idle("wr_post");
  endtask

  task automatic rd_check(input int idx, input string tag);
    q_rd.push_back(m_mem[idx]);
    rd_en   = 1'b1;
    rd_addr = IW'(idx);
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, q_rd.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_wr  = '0;
    m_err = '0;
    q_wr.delete();
    q_err.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [255:0] a5;
    logic [255:0] old5;
    a5 = {32{8'hA5}};

    #12;
    rst = 1'b0;
    chk("rst_awready", 256'(axi_awready), 256'(1));
    chk("rst_wready", 256'(axi_wready), 256'(1));
    chk("rst_bvalid", 256'(axi_bvalid), 256'(0));
    chk("rst_wr_count", 256'(wr_count), 256'(0));
    chk("rst_err_count", 256'(err_count), 256'(0));
    chk("rst_rd_data", rd_data, 256'(0));
    tick();

    // AW and W together, bready high: single-cycle B two edges later
    expect_write(BASE + 64'd64, a5);
    axi_awaddr = BASE + 64'd64;
    axi_wdata  = a5;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    chk("t1_bvalid_t", 256'(axi_bvalid), 256'(0));
    chk("t1_awready_held", 256'(axi_awready), 256'(0));
    tick();
    chk("t1_bvalid_t1", 256'(axi_bvalid), 256'(1));
    tick();
    chk("t1_bvalid_t2", 256'(axi_bvalid), 256'(0));
    chk("t1_awready_t2", 256'(axi_awready), 256'(1));
    chk("t1_wready_t2", 256'(axi_wready), 256'(1));
    rd_check(2, "t1_rd2");
    chk("t1_wr_count", 256'(wr_count), 256'(1));

    // W three cycles ahead of AW
    expect_write(BASE + 64'd96, {8{32'hC0DE_0003}});
    axi_wdata  = {8{32'hC0DE_0003}};
    axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    chk("t2_wready_low", 256'(axi_wready), 256'(0));
    chk("t2_awready_open", 256'(axi_awready), 256'(1));
    tick();
    tick();
    chk("t2_no_early_b", 256'(axi_bvalid), 256'(0));
    axi_awaddr  = BASE + 64'd96;
    axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    chk("t2_bvalid_t", 256'(axi_bvalid), 256'(0));
    tick();
    chk("t2_bvalid_t1", 256'(axi_bvalid), 256'(1));
    wait_idle("t2");
    rd_check(3, "t2_rd3");

    // Out-of-range writes must leave memory and wr_count alone
    wr(BASE, {4{64'hFACE_0000_0000_0000}});
    do_reset();
    tick();
    chk("t3_rd_data_reset", rd_data, 256'(0));
    wr(BASE + 64'd4, {8{32'hDEAD_BEEF}});
    wr(BASE + 64'(32 * NW), {8{32'hBAD0_BAD0}});
    chk("t3_err_count", 256'(err_count), 256'(2));
    chk("t3_wr_count", 256'(wr_count), 256'(0));
    rd_check(0, "t3_word0_kept");
    wr(BASE - 64'd32, {8{32'h1234_5678}});
    chk("t3_below_base", 256'(err_count), 256'(3));

    // Backpressure on B: everything stalls until the handshake
    axi_bready = 1'b0;
    expect_write(BASE + 64'd160, {8{32'h0000_0A0A}});
    axi_awaddr  = BASE + 64'd160;
    axi_wdata   = {8{32'h0000_0A0A}};
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    tick();
    expect_write(BASE + 64'd192, {8{32'h0000_0B0B}});
    axi_awaddr  = BASE + 64'd192;
    axi_wdata   = {8{32'h0000_0B0B}};
    axi_awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_bvalid_hold", 256'(axi_bvalid), 256'(1));
      chk("t4_awready_low", 256'(axi_awready), 256'(0));
      chk("t4_wready_low", 256'(axi_wready), 256'(0));
      tick();
    end
    axi_bready = 1'b1;
    tick();
    chk("t4_b_cleared", 256'(axi_bvalid), 256'(0));
    chk("t4_awready_back", 256'(axi_awready), 256'(1));
    tick();
    axi_awvalid = 1'b0;
    chk("t4_aw2_taken", 256'(axi_awready), 256'(0));
    axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    wait_idle("t4");
    rd_check(5, "t4_rd5");
    rd_check(6, "t4_rd6");

    // Commit and side read of the same word on the same edge
    old5 = m_mem[5];
    q_rd.push_back(old5);
    expect_write(BASE + 64'd160, {8{32'h5555_AAAA}});
    axi_awaddr  = BASE + 64'd160;
    axi_wdata   = {8{32'h5555_AAAA}};
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    rd_en   = 1'b1;
    rd_addr = IW'(5);
    tick();
    rd_en = 1'b0;
    chk("t5_same_edge_old", rd_data, q_rd.pop_front());
    rd_check(5, "t5_next_new");
    wait_idle("t5");

    // Reset with only AW held: the write must vanish
    axi_awaddr  = BASE + 64'd224;
    axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    chk("t6_aw_held", 256'(axi_awready), 256'(0));
    do_reset();
    chk("t6_bvalid", 256'(axi_bvalid), 256'(0));
    chk("t6_awready", 256'(axi_awready), 256'(1));
    chk("t6_wready", 256'(axi_wready), 256'(1));
    chk("t6_wr_count", 256'(wr_count), 256'(0));
    chk("t6_err_count", 256'(err_count), 256'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_b", 256'(axi_bvalid), 256'(0));
    end
    wr(BASE + 64'd224, {8{32'h7777_0007}});
    chk("t6_after_wr_count", 256'(wr_count), 256'(1));
    rd_check(7, "t6_rd7");

    chk("b_queue_drained", 256'(q_wr.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
